// File: rtl/uart_dut_pkg.sv
// rtl/uart_dut_pkg.sv - shared types, defaults and parity helper for the UART transmitter
package uart_dut_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int DEFAULT_BAUD_DIV   = 434;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int MAX_DATA_WIDTH     = 9;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter; bit_end marks the last pclk cycle of each bit
module uart_baud_gen #(
    parameter int BAUD_DIV = uart_dut_pkg::DEFAULT_BAUD_DIV
) (
    input  logic pclk,
    input  logic areset,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int            CW   = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge pclk) begin
        if (areset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
        end
    end

    assign bit_end = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter: valid/ready word in, LSB-first serial frame out
module uart_tx_core
    import uart_dut_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int             BCW       = $clog2(DATA_WIDTH);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_tx_core: BAUD_DIV must be >= 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("uart_tx_core: DATA_WIDTH must be 5..9");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_par_en
        $error("uart_tx_core: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par_odd
        $error("uart_tx_core: PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_core: STOP_BITS must be 1 or 2");
    end

    tx_state_e             state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [BCW-1:0]        bit_cnt, bit_cnt_nxt;
    logic                  par_bit, par_bit_nxt;
    logic                  tx_nxt, done_nxt;
    logic                  accept, bit_end;

    assign accept = (state == IDLE) && tx_valid && tx_ready;

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .pclk    (pclk),
        .areset  (areset),
        .clear   (accept),
        .enable  (state != IDLE),
        .bit_end (bit_end)
    );

    // bit_cnt indexes data bits in DATA and is reused to count stop bits in STOP.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        par_bit_nxt = par_bit;
        done_nxt    = 1'b0;
        unique case (state)
            IDLE: if (accept) begin
                state_nxt   = START;
                shreg_nxt   = tx_data;
                par_bit_nxt = calc_parity(MAX_DATA_WIDTH'(tx_data), PARITY_ODD != 0);
            end
            START: if (bit_end) begin
                state_nxt   = DATA;
                bit_cnt_nxt = '0;
            end
            DATA: if (bit_end) begin
                shreg_nxt = shreg >> 1;
                if (bit_cnt == LAST_DATA) begin
                    bit_cnt_nxt = '0;
                    state_nxt   = (PARITY_EN != 0) ? PARITY : STOP;
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            PARITY: if (bit_end) begin
                state_nxt = STOP;
            end
            STOP: if (bit_end) begin
                if (bit_cnt == LAST_STOP) begin
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                    done_nxt    = 1'b1;
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            PARITY:  tx_nxt = par_bit;
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (areset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_cnt  <= bit_cnt_nxt;
            par_bit  <= par_bit_nxt;
            tx       <= tx_nxt;
            tx_ready <= (state_nxt == IDLE);
            tx_busy  <= (state_nxt != IDLE);
            tx_done  <= done_nxt;
        end
    end

endmodule
